// File: rtl/pipelined_decode_stage_pkg.sv
// Shared decode definitions: opcodes, control-field widths and encodings,
// and the opcode-to-control decode function used by the decode stage.
package pipelined_decode_stage_pkg;

  localparam int WB_W   = 2;
  localparam int MEM_W  = 3;
  localparam int CALC_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [MEM_W-1:0] MEM_NONE  = 3'b000;
  localparam logic [MEM_W-1:0] MEM_LOAD  = 3'b001;
  localparam logic [MEM_W-1:0] MEM_STORE = 3'b010;

  typedef struct packed {
    logic [WB_W-1:0]   wb;
    logic [MEM_W-1:0]  mem;
    logic [CALC_W-1:0] calc;
  } ctrl_t;

  // wb[0] = register write, wb[1] = result comes from memory
  function automatic ctrl_t decode_opcode(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: begin c.wb = 2'b01; c.mem = MEM_NONE;  c.calc = 4'b0001; end
      OP_ADDI:  begin c.wb = 2'b01; c.mem = MEM_NONE;  c.calc = 4'b0010; end
      OP_LW:    begin c.wb = 2'b11; c.mem = MEM_LOAD;  c.calc = 4'b0010; end
      OP_SW:    begin c.wb = 2'b00; c.mem = MEM_STORE; c.calc = 4'b0010; end
      OP_BEQ:   begin c.wb = 2'b00; c.mem = MEM_NONE;  c.calc = 4'b0100; end
      default:  c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pipelined_register_file.sv
// Register file: two combinational read ports, one clocked write port.
// Register 0 is hardwired to zero; contents clear on reset.
module pipelined_register_file #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [REG_ADDR_W-1:0] raddr1,
  input  logic [REG_ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0]     rdata1,
  output logic [DATA_W-1:0]     rdata2
);

  localparam int DEPTH = 2 ** REG_ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we && waddr != '0) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata1 = (raddr1 == '0) ? '0 : mem_q[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 : mem_q[raddr2];

endmodule

// File: rtl/pipelined_decode_stage.sv
// Decode stage: reads operands (with write-back bypass), decodes control,
// sign-extends the immediate and stalls behind a load-use hazard.
module pipelined_decode_stage
  import pipelined_decode_stage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   inValid,
  output logic                   inReady,
  input  logic [DATA_W-1:0]      programCounterIn,
  input  logic [31:0]            instruction,
  input  logic                   flush,
  input  logic [REG_ADDR_W-1:0]  writeRegister,
  input  logic [DATA_W-1:0]      writeData,
  input  logic                   regWrite,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [WB_W-1:0]        writeBackControl,
  output logic [MEM_W-1:0]       memAccessControl,
  output logic [CALC_W-1:0]      calculationControl,
  output logic [DATA_W-1:0]      programCounterOut,
  output logic [DATA_W-1:0]      readData1,
  output logic [DATA_W-1:0]      readData2,
  output logic [DATA_W-1:0]      immediateOperand,
  output logic [REG_ADDR_W-1:0]  writeRegister0,
  output logic [REG_ADDR_W-1:0]  writeRegister1,
  output logic [STALL_CNT_W-1:0] stallCount
);

  // Handshake: upstream transfers when inValid && inReady (and no flush);
  // downstream transfers when outValid && outReady. Bundle holds otherwise.

  logic [REG_ADDR_W-1:0] rs, rt, rd;
  logic [DATA_W-1:0]     rf_rdata1, rf_rdata2, op1, op2, imm_ext;
  logic                  hold, hazard, accept, wb_en;
  ctrl_t                 ctrl_dec;

  logic                   out_valid_q, out_valid_d;
  ctrl_t                  ctrl_q, ctrl_d;
  logic [DATA_W-1:0]      pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [REG_ADDR_W-1:0]  wr0_q, wr0_d, wr1_q, wr1_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign rs = REG_ADDR_W'(instruction[25:21]);
  assign rt = REG_ADDR_W'(instruction[20:16]);
  assign rd = REG_ADDR_W'(instruction[15:11]);

  assign wb_en = regWrite && (writeRegister != '0);

  pipelined_register_file #(
    .DATA_W    (DATA_W),
    .REG_ADDR_W(REG_ADDR_W)
  ) u_regfile (
    .clk   (clk),
    .resetN(resetN),
    .we    (wb_en),
    .waddr (writeRegister),
    .wdata (writeData),
    .raddr1(rs),
    .raddr2(rt),
    .rdata1(rf_rdata1),
    .rdata2(rf_rdata2)
  );

  // Same-cycle write-back is forwarded so the bundle never sees stale data.
  assign op1      = (wb_en && writeRegister == rs) ? writeData : rf_rdata1;
  assign op2      = (wb_en && writeRegister == rt) ? writeData : rf_rdata2;
  assign imm_ext  = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};
  assign ctrl_dec = decode_opcode(instruction[31:26]);

  assign hold    = out_valid_q && !outReady;
  assign hazard  = out_valid_q && (ctrl_q.mem == MEM_LOAD) && (wr0_q != '0) &&
                   (wr0_q == rs || wr0_q == rt);
  assign inReady = !hold && !hazard;
  assign accept  = inValid && inReady && !flush;

  always_comb begin
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    pc_d        = pc_q;
    rd1_d       = rd1_q;
    rd2_d       = rd2_q;
    imm_d       = imm_q;
    wr0_d       = wr0_q;
    wr1_d       = wr1_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (!hold) begin
      if (accept) begin
        out_valid_d = 1'b1;
        ctrl_d      = ctrl_dec;
        pc_d        = programCounterIn;
        rd1_d       = op1;
        rd2_d       = op2;
        imm_d       = imm_ext;
        wr0_d       = rt;
        wr1_d       = rd;
      end else begin
        out_valid_d = 1'b0;
      end
    end
    if (inValid && hazard && !flush && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      pc_q        <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
      wr0_q       <= '0;
      wr1_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      pc_q        <= pc_d;
      rd1_q       <= rd1_d;
      rd2_q       <= rd2_d;
      imm_q       <= imm_d;
      wr0_q       <= wr0_d;
      wr1_q       <= wr1_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign outValid           = out_valid_q;
  assign writeBackControl   = ctrl_q.wb;
  assign memAccessControl   = ctrl_q.mem;
  assign calculationControl = ctrl_q.calc;
  assign programCounterOut  = pc_q;
  assign readData1          = rd1_q;
  assign readData2          = rd2_q;
  assign immediateOperand   = imm_q;
  assign writeRegister0     = wr0_q;
  assign writeRegister1     = wr1_q;
  assign stallCount         = stall_cnt_q;

endmodule

// File: tb/tb_pipelined_decode_stage.sv
// Directed bench for pipelined_decode_stage: reset, bypass, immediates,
// load-use stall, output hold, flush and reset during a stall.
module tb_pipelined_decode_stage;
  import pipelined_decode_stage_pkg::*;

  localparam int DATA_W      = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int STALL_CNT_W = 16;

  logic                   clk = 1'b0;
  logic                   resetN;
  logic                   inValid;
  logic                   inReady;
  logic [DATA_W-1:0]      programCounterIn;
  logic [31:0]            instruction;
  logic                   flush;
  logic [REG_ADDR_W-1:0]  writeRegister;
  logic [DATA_W-1:0]      writeData;
  logic                   regWrite;
  logic                   outValid;
  logic                   outReady;
  logic [WB_W-1:0]        writeBackControl;
  logic [MEM_W-1:0]       memAccessControl;
  logic [CALC_W-1:0]      calculationControl;
  logic [DATA_W-1:0]      programCounterOut;
  logic [DATA_W-1:0]      readData1;
  logic [DATA_W-1:0]      readData2;
  logic [DATA_W-1:0]      immediateOperand;
  logic [REG_ADDR_W-1:0]  writeRegister0;
  logic [REG_ADDR_W-1:0]  writeRegister1;
  logic [STALL_CNT_W-1:0] stallCount;

  int total = 0;
  int bad   = 0;

  pipelined_decode_stage #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W),
    .STALL_CNT_W(STALL_CNT_W)
  ) dut (
    .clk               (clk),
    .resetN            (resetN),
    .inValid           (inValid),
    .inReady           (inReady),
    .programCounterIn  (programCounterIn),
    .instruction       (instruction),
    .flush             (flush),
    .writeRegister     (writeRegister),
    .writeData         (writeData),
    .regWrite          (regWrite),
    .outValid          (outValid),
    .outReady          (outReady),
    .writeBackControl  (writeBackControl),
    .memAccessControl  (memAccessControl),
    .calculationControl(calculationControl),
    .programCounterOut (programCounterOut),
    .readData1         (readData1),
    .readData2         (readData2),
    .immediateOperand  (immediateOperand),
    .writeRegister0    (writeRegister0),
    .writeRegister1    (writeRegister1),
    .stallCount        (stallCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    resetN = 1'b0; inValid = 1'b0; programCounterIn = '0; instruction = '0;
    flush = 1'b0; writeRegister = '0; writeData = '0; regWrite = 1'b0; outReady = 1'b1;

    #3;
    check("rst_out_valid", 64'(outValid), 64'd0);
    check("rst_stall", 64'(stallCount), 64'd0);
    check("rst_rd1", 64'(readData1), 64'd0);
    check("rst_imm", 64'(immediateOperand), 64'd0);
    check("rst_in_ready", 64'(inReady), 64'd1);
    step(); step();
    resetN = 1'b1;

    // write r3 = 5, then decode add rs=3, rd=1
    regWrite = 1'b1; writeRegister = 5'd3; writeData = 32'd5;
    step();
    regWrite = 1'b0;
    instruction = mk(OP_RTYPE, 5'd3, 5'd0, 16'h0800); programCounterIn = 32'h100; inValid = 1'b1;
    step();
    inValid = 1'b0;
    check("add_valid", 64'(outValid), 64'd1);
    check("add_rd1", 64'(readData1), 64'd5);
    check("add_rd2", 64'(readData2), 64'd0);
    check("add_wr1", 64'(writeRegister1), 64'd1);
    check("add_pc", 64'(programCounterOut), 64'h100);
    check("add_wb", 64'(writeBackControl), 64'd1);
    check("add_calc", 64'(calculationControl), 64'd1);
    check("add_mem", 64'(memAccessControl), 64'd0);
    step();
    check("idle_valid", 64'(outValid), 64'd0);

    // same-cycle bypass, then write to r0 ignored
    regWrite = 1'b1; writeRegister = 5'd4; writeData = 32'hA5;
    instruction = mk(OP_RTYPE, 5'd4, 5'd3, 16'h0000); inValid = 1'b1;
    step();
    check("byp_rd1", 64'(readData1), 64'hA5);
    check("byp_rd2", 64'(readData2), 64'd5);
    writeRegister = 5'd0; writeData = 32'hFFFF;
    instruction = mk(OP_RTYPE, 5'd0, 5'd4, 16'h0000);
    step();
    regWrite = 1'b0;
    check("r0_rd1", 64'(readData1), 64'd0);
    check("r4_rd2", 64'(readData2), 64'hA5);

    // immediates and unknown opcode
    instruction = mk(OP_ADDI, 5'd0, 5'd2, 16'h8000);
    step();
    check("imm_neg", 64'(immediateOperand), 64'hFFFF8000);
    check("addi_wb", 64'(writeBackControl), 64'd1);
    check("addi_calc", 64'(calculationControl), 64'd2);
    instruction = mk(6'h3F, 5'd0, 5'd2, 16'h7FFF);
    step();
    check("imm_pos", 64'(immediateOperand), 64'h00007FFF);
    check("unk_wb", 64'(writeBackControl), 64'd0);
    check("unk_calc", 64'(calculationControl), 64'd0);
    check("unk_mem", 64'(memAccessControl), 64'd0);

    // load rt=7, then dependent rs=7
    instruction = mk(OP_LW, 5'd0, 5'd7, 16'h0000);
    step();
    check("lw_mem", 64'(memAccessControl), 64'(MEM_LOAD));
    check("lw_wr0", 64'(writeRegister0), 64'd7);
    instruction = mk(OP_RTYPE, 5'd7, 5'd0, 16'h1000);
    #1;
    check("haz_in_ready", 64'(inReady), 64'd0);
    step();
    check("bubble_valid", 64'(outValid), 64'd0);
    check("bubble_stall", 64'(stallCount), 64'd1);
    check("post_haz_ready", 64'(inReady), 64'd1);
    step();
    check("dep_valid", 64'(outValid), 64'd1);
    check("dep_wr1", 64'(writeRegister1), 64'd2);
    check("dep_stall", 64'(stallCount), 64'd1);

    // hold for 3 cycles
    instruction = mk(OP_ADDI, 5'd3, 5'd9, 16'h0042);
    step();
    check("pre_hold_rd1", 64'(readData1), 64'd5);
    outReady = 1'b0;
    instruction = mk(OP_ADDI, 5'd4, 5'd1, 16'h0011);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("hold_in_ready", 64'(inReady), 64'd0);
      step();
      check("hold_valid", 64'(outValid), 64'd1);
      check("hold_rd1", 64'(readData1), 64'd5);
      check("hold_imm", 64'(immediateOperand), 64'h42);
    end
    outReady = 1'b1;
    #1;
    check("release_ready", 64'(inReady), 64'd1);
    step();
    check("release_valid", 64'(outValid), 64'd1);
    check("release_rd1", 64'(readData1), 64'hA5);
    check("release_imm", 64'(immediateOperand), 64'h11);

    // flush during hold, with a write-back in the same cycle
    outReady = 1'b0; flush = 1'b1;
    instruction = mk(OP_ADDI, 5'd0, 5'd0, 16'h0055);
    regWrite = 1'b1; writeRegister = 5'd5; writeData = 32'h1234;
    step();
    flush = 1'b0; regWrite = 1'b0; inValid = 1'b0;
    #1;
    check("flush_valid", 64'(outValid), 64'd0);
    check("flush_stall", 64'(stallCount), 64'd1);
    check("flush_ready", 64'(inReady), 64'd1);
    outReady = 1'b1;
    instruction = mk(OP_RTYPE, 5'd5, 5'd0, 16'h0000); inValid = 1'b1;
    step();
    check("flush_wb_rd1", 64'(readData1), 64'h1234);

    // reset asserted during a load-use stall
    instruction = mk(OP_LW, 5'd0, 5'd8, 16'h0000);
    step();
    instruction = mk(OP_RTYPE, 5'd8, 5'd0, 16'h0000);
    #1;
    check("stall2_ready", 64'(inReady), 64'd0);
    #2;
    resetN = 1'b0;
    #1;
    check("mrst_valid", 64'(outValid), 64'd0);
    check("mrst_stall", 64'(stallCount), 64'd0);
    check("mrst_wr0", 64'(writeRegister0), 64'd0);
    check("mrst_mem", 64'(memAccessControl), 64'd0);
    inValid = 1'b0;
    step();
    resetN = 1'b1;
    step();
    check("post_rst_valid", 64'(outValid), 64'd0);
    instruction = mk(OP_RTYPE, 5'd3, 5'd5, 16'h0000); inValid = 1'b1;
    step();
    inValid = 1'b0;
    check("cleared_rd1", 64'(readData1), 64'd0);
    check("cleared_rd2", 64'(readData2), 64'd0);
    check("cleared_valid", 64'(outValid), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipelined_decode_stage.md
PIPELINED_DECODE_STAGE -- requirements
Module: pipelined_decode_stage

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register, PC and immediate width (minimum 16).
REQ-002 Parameter REG_ADDR_W, default 5, SHALL set the register-index width; register file depth SHALL be 2**REG_ADDR_W.
REQ-003 Parameter STALL_CNT_W, default 16, SHALL set the stall-counter width.
REQ-004 Ports, in this order:
- clk  in  1  single clock; all state updates on the rising edge.
- resetN  in  1  asynchronous, active-low reset.
- inValid  in  1  upstream instruction valid.
- inReady  out  1  stage accepts an instruction this cycle.
- programCounterIn  in  DATA_W  PC of the incoming instruction.
- instruction  in  32  rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0], opcode=[31:26].
- flush  in  1  discard the stage contents and the incoming instruction.
- writeRegister  in  REG_ADDR_W  write-back index.
- writeData  in  DATA_W  write-back data.
- regWrite  in  1  write-back enable.
- outValid  out  1  output bundle valid.
- outReady  in  1  downstream accepts the bundle.
- writeBackControl  out  2;  memAccessControl  out  3;  calculationControl  out  4: control fields.
- programCounterOut, readData1, readData2, immediateOperand  out  DATA_W each.
- writeRegister0 (rt), writeRegister1 (rd)  out  REG_ADDR_W each.
- stallCount  out  STALL_CNT_W  count of hazard-stall cycles.

Function
REQ-005 The stage SHALL register all bundle outputs on the rising edge of clk when an instruction is accepted (inValid && inReady && !flush); latency SHALL be 1 cycle.
REQ-006 Hold SHALL be outValid && !outReady; during hold, all outputs SHALL stay stable.
REQ-007 inReady SHALL equal !hold && !hazard.
REQ-008 hazard SHALL be true when all of the following hold: outValid, memAccessControl marks a load (package constant), writeRegister0 != 0, and writeRegister0 equals incoming rs or rt.
REQ-009 During hazard with !hold, the stage SHALL load a bubble (outValid=0); the instruction SHALL be re-presented by upstream and accepted the following cycle.
REQ-010 stallCount SHALL increment once per cycle in which inValid && hazard && !flush holds; it SHALL saturate at all-ones.
REQ-011 Register reads SHALL be combinational from the register file; register 0 SHALL read as 0 and SHALL ignore writes.
REQ-012 Write-back SHALL take effect on the rising edge of clk when regWrite is high and writeRegister != 0.
REQ-013 Bypass: if regWrite is high, writeRegister != 0, and writeRegister equals rs (or rt) in the same cycle, readData1 (or readData2) SHALL capture writeData.
REQ-014 immediateOperand SHALL be instruction[15:0] sign-extended to the full DATA_W, replicating bit 15 DATA_W-16 times.
REQ-015 Control fields SHALL come from the package opcode-decode function; an unknown opcode SHALL yield all-zero control (no-op).
REQ-016 flush SHALL take priority over all else: next cycle outValid=0, the incoming instruction is dropped, inReady=1, and stallCount is unchanged; register-file writes SHALL still occur.
REQ-017 When outValid=0, the stage SHALL accept a new instruction regardless of outReady.

Reset
REQ-018 When resetN=0, the stage SHALL immediately set outValid=0, stallCount=0, and all bundle outputs to 0.
REQ-019 Register-file contents SHALL be cleared to 0 on reset.
REQ-020 Reset asserted mid-hold or mid-stall SHALL drop the in-flight instruction.

Structure
REQ-021 A shared package SHALL hold the opcode constants, the load-marker encoding of memAccessControl, the control-field widths, and the decode function.
REQ-022 The register file SHALL be a sub-module, pipelined_register_file, parametrised by DATA_W and REG_ADDR_W, with 2 read ports and 1 write port.

Verification
REQ-023 Reset, then load r3=5 via write-back and decode add rs=3 -> one cycle later outValid=1 and readData1=5.
REQ-024 Same-cycle write-back r4=0xA5 while decoding rs=4 -> readData1=0xA5; rs=0 with write-back to r0 -> readData1=0.
REQ-025 Load writing rt=7, then an instruction with rs=7 -> inReady=0 for 1 cycle, a bubble on the output, the second instruction accepted next cycle, stallCount=1.
REQ-026 outReady=0 for 3 cycles with outValid=1 -> outputs stable and inReady=0; on release, the next instruction is accepted.
REQ-027 imm=0x8000 with DATA_W=32 -> immediateOperand=0xFFFF8000; imm=0x7FFF -> 0x00007FFF.
REQ-028 flush during hold, and resetN pulsed mid-stall -> outValid=0 next cycle (immediately for reset); stallCount is unchanged after flush and 0 after reset.
